// File: rtl/rw_common_pkg.sv
// Shared constants and helpers for the synchronizer / debounce family.
package rw_common_pkg;

  localparam int SYNC_MIN_STAGES = 2;
  localparam int SYNC_MAX_STAGES = 4;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_debounce_ch.sv
// One channel: STAGES-deep synchronizer, debounce counter, optional edge pulses.
// Edge pulse flops exist only when SYNC_EDGE_DETECT_EN is defined.
module sync_debounce_ch
  import rw_common_pkg::*;
#(
  parameter int   STAGES     = 2,
  parameter int   DEB_CYCLES = 4,
  parameter logic INIVAL_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  localparam int              CW       = (clog2(DEB_CYCLES) < 1) ? 1 : clog2(DEB_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [STAGES-1:0] r_chain;
  logic [CW-1:0]     r_cnt;
  logic              r_out;
  logic              w_s;
  logic              w_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= {STAGES{INIVAL_BIT}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_async};
    end
  end

  assign w_s      = r_chain[STAGES-1];
  assign w_accept = (w_s != r_out) && (r_cnt == CNT_LAST);

  // Any return to the current level restarts the count, so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_out <= INIVAL_BIT;
    end else if (w_s == r_out) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_out <= w_s;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_sync = r_out;

`ifdef SYNC_EDGE_DETECT_EN
  logic r_rise;
  logic r_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_accept && w_s;
      r_fall <= w_accept && !w_s;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;
`else
  assign o_rise = 1'b0;
  assign o_fall = 1'b0;
`endif

endmodule

// File: rtl/sync_debounce.sv
// Multi-channel synchronizer + debounce filter; WIDTH independent channels.
// Define SYNC_EDGE_DETECT_EN to enable the rise/fall pulse outputs.
module sync_debounce
  import rw_common_pkg::*;
#(
  parameter int               WIDTH      = 1,
  parameter int               STAGES     = 2,
  parameter logic [WIDTH-1:0] INIVAL     = '0,
  parameter int               DEB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  if (STAGES < SYNC_MIN_STAGES || STAGES > SYNC_MAX_STAGES) begin : g_bad_stages
    $error("sync_debounce: STAGES=%0d outside %0d..%0d", STAGES, SYNC_MIN_STAGES, SYNC_MAX_STAGES);
  end

  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("sync_debounce: DEB_CYCLES=%0d must be >= 1", DEB_CYCLES);
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    sync_debounce_ch #(
      .STAGES     (STAGES),
      .DEB_CYCLES (DEB_CYCLES),
      .INIVAL_BIT (INIVAL[g])
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (async_in[g]),
      .o_sync  (sync_out[g]),
      .o_rise  (rise_pulse[g]),
      .o_fall  (fall_pulse[g])
    );
  end

endmodule

// File: tb/tb_sync_debounce.sv
// Bench for sync_debounce: window-based reference model plus directed checks.
// Pulse expectations follow SYNC_EDGE_DETECT_EN as compiled.
module tb_sync_debounce;

  localparam int          ST  = 2;
  localparam int          DEB = 4;
  localparam logic [15:0] INI = 16'hFFFF;
`ifdef SYNC_EDGE_DETECT_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] async_in;
  logic [15:0] sync_out, rise_pulse, fall_pulse;
  logic [0:0]  async2, sync2, rise2, fall2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sync_debounce #(
    .WIDTH(16), .STAGES(ST), .INIVAL(INI), .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .async_in(async_in),
    .sync_out(sync_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse)
  );

  sync_debounce #(
    .WIDTH(1), .STAGES(3), .INIVAL(1'b0), .DEB_CYCLES(1)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .async_in(async2),
    .sync_out(sync2), .rise_pulse(rise2), .fall_pulse(fall2)
  );

  // Model: output takes level v once the last DEB synchronized samples all equal v.
  // Synchronized sample used at edge n is the input driven before edge n-ST.
  logic [15:0] m_hist [0:ST+DEB-1];
  logic [15:0] m_out, m_rise, m_fall;
  logic [15:0] m_all1, m_any1, m_up, m_dn;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < ST + DEB; j++) m_hist[j] = INI;
      m_out  = INI;
      m_rise = '0;
      m_fall = '0;
    end else begin
      for (int j = ST + DEB - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = async_in;
      m_all1 = '1;
      m_any1 = '0;
      for (int j = ST; j < ST + DEB; j++) begin
        m_all1 = m_all1 & m_hist[j];
        m_any1 = m_any1 | m_hist[j];
      end
      m_up   = ~m_out & m_all1;
      m_dn   = m_out & ~m_any1;
      m_out  = (m_out | m_up) & ~m_dn;
      m_rise = EDGE_EN ? m_up : 16'h0000;
      m_fall = EDGE_EN ? m_dn : 16'h0000;
    end
  end

  always @(negedge clk) begin
    n_checks++;
    if ({sync_out, rise_pulse, fall_pulse} !== {m_out, m_rise, m_fall}) begin
      n_errors++;
      $display("FAIL model_cmp t=%0t sync_out=%h rise=%h fall=%h, expected sync_out=%h rise=%h fall=%h",
               $time, sync_out, rise_pulse, fall_pulse, m_out, m_rise, m_fall);
    end
  end

  logic [15:0] seen_rise, seen_fall;
  int          rise3_cnt;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      seen_rise = seen_rise | rise_pulse;
      seen_fall = seen_fall | fall_pulse;
      if (rise_pulse[3]) rise3_cnt++;
    end
  endtask

  function automatic logic [15:0] exp_p(input logic [15:0] x);
    return EDGE_EN ? x : 16'h0000;
  endfunction

  task automatic clr_seen();
    seen_rise = '0;
    seen_fall = '0;
    rise3_cnt = 0;
  endtask

  initial begin
    #100000;
    n_errors++;
    $display("FAIL watchdog t=%0t simulation did not complete", $time);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    async_in = 16'h0000;
    async2   = 1'b0;
    clr_seen();

    // 1: reset value, then release with input differing from INIVAL
    tick(2);
    chk("t1_rst_sync", sync_out, 16'hFFFF);
    chk("t1_rst_rise", rise_pulse, 16'h0000);
    chk("t1_rst_fall", fall_pulse, 16'h0000);
    rst_n = 1'b1;
    tick(5);
    chk("t1_hold_5", sync_out, 16'hFFFF);
    tick(1);
    chk("t1_sync_6", sync_out, 16'h0000);
    chk("t1_fall_6", fall_pulse, exp_p(16'hFFFF));
    chk("t1_rise_6", rise_pulse, 16'h0000);
    tick(1);
    chk("t1_fall_end", fall_pulse, 16'h0000);

    // 2: multi-bit change
    async_in = 16'h5555;
    tick(5);
    chk("t2_hold_5", sync_out, 16'h0000);
    tick(1);
    chk("t2_sync_6", sync_out, 16'h5555);
    chk("t2_rise_6", rise_pulse, exp_p(16'h5555));
    chk("t2_fall_6", fall_pulse, 16'h0000);
    tick(1);
    chk("t2_rise_end", rise_pulse, 16'h0000);

    // 3: glitch of 3 clocks rejected, 4 clocks accepted
    async_in = 16'h0000;
    tick(8);
    chk("t3_settle", sync_out, 16'h0000);
    clr_seen();
    async_in = 16'h0001;
    tick(3);
    async_in = 16'h0000;
    tick(8);
    chk("t3_glitch_sync", sync_out, 16'h0000);
    chk("t3_glitch_rise", seen_rise, 16'h0000);
    chk("t3_glitch_fall", seen_fall, 16'h0000);
    async_in = 16'h0001;
    tick(4);
    async_in = 16'h0000;
    tick(1);
    chk("t3_pre_accept", sync_out, 16'h0000);
    tick(1);
    chk("t3_accept", sync_out, 16'h0001);
    chk("t3_rise", rise_pulse, exp_p(16'h0001));
    tick(3);
    chk("t3_still_high", sync_out, 16'h0001);
    tick(1);
    chk("t3_back_low", sync_out, 16'h0000);
    chk("t3_fall", fall_pulse, exp_p(16'h0001));

    // 4: bit3 chatters every 2 clocks, then settles high
    tick(3);
    clr_seen();
    for (int i = 0; i < 20; i++) begin
      async_in = ((i % 4) < 2) ? 16'h0008 : 16'h0000;
      tick(1);
    end
    chk("t4_chatter_sync", sync_out, 16'h0000);
    chk("t4_chatter_rise", seen_rise, 16'h0000);
    async_in = 16'h0008;
    tick(5);
    chk("t4_hold_5", sync_out, 16'h0000);
    tick(1);
    chk("t4_sync_6", sync_out, 16'h0008);
    tick(4);
    chk("t4_rise_count", 16'(rise3_cnt), EDGE_EN ? 16'd1 : 16'd0);
    chk("t4_other_rise", seen_rise & ~16'h0008, 16'h0000);
    chk("t4_no_fall", seen_fall, 16'h0000);

    // 5: async reset in the middle of a count
    async_in = 16'h0000;
    tick(4);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_rst_sync", sync_out, 16'hFFFF);
    chk("t5_rst_rise", rise_pulse, 16'h0000);
    chk("t5_rst_fall", fall_pulse, 16'h0000);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk("t5_hold_5", sync_out, 16'hFFFF);
    tick(1);
    chk("t5_sync_6", sync_out, 16'h0000);
    chk("t5_fall_6", fall_pulse, exp_p(16'hFFFF));

    // 6: single channel, 3 stages, no filtering
    async2 = 1'b1;
    tick(3);
    chk("t6_hold_3", {15'b0, sync2}, 16'h0000);
    tick(1);
    chk("t6_sync_4", {15'b0, sync2}, 16'h0001);
    chk("t6_rise_4", {15'b0, rise2}, exp_p(16'h0001));
    chk("t6_fall_4", {15'b0, fall2}, 16'h0000);
    tick(1);
    chk("t6_rise_end", {15'b0, rise2}, 16'h0000);
    async2 = 1'b0;
    tick(3);
    chk("t6_hold_low_3", {15'b0, sync2}, 16'h0001);
    tick(1);
    chk("t6_low_4", {15'b0, sync2}, 16'h0000);
    chk("t6_fall_low_4", {15'b0, fall2}, exp_p(16'h0001));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
